// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, write/read FSM states and
// the helper that turns the data width into the byte-offset address bits.
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_COMMIT = 2'd1,
      WR_RESP   = 2'd2
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_t;

   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axi4_lite_strb_regfile.sv
// NUM_REGS x DATA_WIDTH register storage: byte-strobed write port, async
// read port, and the whole array exported flat (reg i at [i*DATA_WIDTH +: DATA_WIDTH]).
module axi4_lite_strb_regfile #(
   parameter  int NUM_REGS   = 16,
   parameter  int DATA_WIDTH = 32,
   localparam int IDX_W      = $clog2(NUM_REGS),
   localparam int STRB_W     = DATA_WIDTH / 8
) (
   input  logic                           gclk,
   input  logic                           grst_n,
   input  logic                           we,
   input  logic [IDX_W-1:0]               wr_idx,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   input  logic [STRB_W-1:0]              wr_strb,
   input  logic [IDX_W-1:0]               rd_idx,
   output logic [DATA_WIDTH-1:0]          rd_data,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem;

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         mem <= '0;
      end else if (we) begin
         for (int b = 0; b < STRB_W; b++)
            if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
   end

   assign rd_data   = mem[rd_idx];
   assign regs_flat = mem;

endmodule

// File: rtl/axi4_lite_subordinate_regfile.sv
// AXI4-Lite subordinate backed by a strobed register file.
// Optional AXI4_LITE_SUB_ADDR_CHECK_EN: out-of-range addresses get SLVERR.
module axi4_lite_subordinate_regfile
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                           ACLK,
   input  logic                           ARESETN,
   input  logic [ADDR_WIDTH-1:0]          AWADDR,
   input  logic [2:0]                     AWPROT,
   input  logic                           AWVALID,
   output logic                           AWREADY,
   input  logic [DATA_WIDTH-1:0]          WDATA,
   input  logic [DATA_WIDTH/8-1:0]        WSTRB,
   input  logic                           WVALID,
   output logic                           WREADY,
   output logic [1:0]                     BRESP,
   output logic                           BVALID,
   input  logic                           BREADY,
   input  logic [ADDR_WIDTH-1:0]          ARADDR,
   input  logic [2:0]                     ARPROT,
   input  logic                           ARVALID,
   output logic                           ARREADY,
   output logic [DATA_WIDTH-1:0]          RDATA,
   output logic [1:0]                     RRESP,
   output logic                           RVALID,
   input  logic                           RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

   localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
   localparam int IDX_W    = $clog2(NUM_REGS);
   localparam int STRB_W   = DATA_WIDTH / 8;

   wr_state_t               wr_state;
   rd_state_t               rd_state;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [STRB_W-1:0]       w_strb;
   logic                    aw_held, w_held;
   logic                    aw_oor, ar_oor;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    aw_hs, w_hs, ar_hs;
   logic                    unused_bits;

   assign aw_hs = AWVALID & AWREADY;
   assign w_hs  = WVALID & WREADY;
   assign ar_hs = ARVALID & ARREADY;

`ifdef AXI4_LITE_SUB_ADDR_CHECK_EN
   assign aw_oor = |(aw_addr >> (ADDR_LSB + IDX_W));
   assign ar_oor = |(ARADDR >> (ADDR_LSB + IDX_W));
`else
   assign aw_oor = 1'b0;
   assign ar_oor = 1'b0;
`endif

   // Protection bits and the byte-offset/alias address bits carry no meaning here.
   assign unused_bits = ^{AWPROT, ARPROT, aw_addr, ARADDR};

   axi4_lite_strb_regfile #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rf (
      .gclk      (ACLK),
      .grst_n    (ARESETN),
      .we        ((wr_state == WR_COMMIT) && !aw_oor),
      .wr_idx    (aw_addr[ADDR_LSB +: IDX_W]),
      .wr_data   (w_data),
      .wr_strb   (w_strb),
      .rd_idx    (ARADDR[ADDR_LSB +: IDX_W]),
      .rd_data   (rd_data),
      .regs_flat (regs_flat)
   );

   // AW and W are captured independently; commit once both are held.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state <= WR_IDLE;
         AWREADY  <= 1'b0;
         WREADY   <= 1'b0;
         BVALID   <= 1'b0;
         BRESP    <= RESP_OKAY;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_addr  <= '0;
         w_data   <= '0;
         w_strb   <= '0;
      end else begin
         case (wr_state)
            WR_IDLE: begin
               if (aw_hs) aw_addr <= AWADDR;
               if (w_hs) begin
                  w_data <= WDATA;
                  w_strb <= WSTRB;
               end
               aw_held <= aw_held | aw_hs;
               w_held  <= w_held | w_hs;
               AWREADY <= !(aw_held | aw_hs);
               WREADY  <= !(w_held | w_hs);
               if ((aw_held | aw_hs) && (w_held | w_hs)) wr_state <= WR_COMMIT;
            end
            WR_COMMIT: begin
               BVALID   <= 1'b1;
               BRESP    <= aw_oor ? RESP_SLVERR : RESP_OKAY;
               aw_held  <= 1'b0;
               w_held   <= 1'b0;
               wr_state <= WR_RESP;
            end
            WR_RESP: begin
               if (BREADY) begin
                  BVALID   <= 1'b0;
                  AWREADY  <= 1'b1;
                  WREADY   <= 1'b1;
                  wr_state <= WR_IDLE;
               end
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end

   // Read data is sampled at the AR handshake, so a same-cycle commit is not visible.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rd_state <= RD_IDLE;
         ARREADY  <= 1'b0;
         RVALID   <= 1'b0;
         RRESP    <= RESP_OKAY;
         RDATA    <= '0;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (ar_hs) begin
                  RDATA    <= ar_oor ? '0 : rd_data;
                  RRESP    <= ar_oor ? RESP_SLVERR : RESP_OKAY;
                  RVALID   <= 1'b1;
                  ARREADY  <= 1'b0;
                  rd_state <= RD_DATA;
               end else begin
                  ARREADY <= 1'b1;
               end
            end
            RD_DATA: begin
               if (RREADY) begin
                  RVALID   <= 1'b0;
                  ARREADY  <= 1'b1;
                  rd_state <= RD_IDLE;
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_subordinate_regfile.sv
// Randomized bench for axi4_lite_subordinate_regfile against an array model of
// the register file; honours AXI4_LITE_SUB_ADDR_CHECK_EN for expected responses.
module tb_axi4_lite_subordinate_regfile;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 16;

   logic           ACLK = 1'b0;
   logic           ARESETN = 1'b0;
   logic [AW-1:0]  AWADDR = '0;
   logic [2:0]     AWPROT = '0;
   logic           AWVALID = 1'b0;
   logic           AWREADY;
   logic [DW-1:0]  WDATA = '0;
   logic [DW/8-1:0] WSTRB = '0;
   logic           WVALID = 1'b0;
   logic           WREADY;
   logic [1:0]     BRESP;
   logic           BVALID;
   logic           BREADY = 1'b0;
   logic [AW-1:0]  ARADDR = '0;
   logic [2:0]     ARPROT = '0;
   logic           ARVALID = 1'b0;
   logic           ARREADY;
   logic [DW-1:0]  RDATA;
   logic [1:0]     RRESP;
   logic           RVALID;
   logic           RREADY = 1'b0;
   logic [NR*DW-1:0] regs_flat;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] model [NR];
   bit wr_busy = 1'b0;
   bit cmp_ok;

   axi4_lite_subordinate_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .regs_flat(regs_flat)
   );

   always #5 ACLK = ~ACLK;

   function automatic int idx_of(input logic [AW-1:0] a);
      return int'(a[5:2]);
   endfunction

   function automatic bit oor_of(input logic [AW-1:0] a);
`ifdef AXI4_LITE_SUB_ADDR_CHECK_EN
      return a[AW-1:6] != '0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare: stored registers vs model whenever no write is in flight,
   // plus channel invariants.
   always @(negedge ACLK) begin
      if (ARESETN) begin
         if (!wr_busy) begin
            cmp_ok = 1'b1;
            for (int i = 0; i < NR; i++)
               if (regs_flat[i*DW +: DW] !== model[i]) begin
                  cmp_ok = 1'b0;
                  $display("FAIL regs_flat[%0d]: got %h expected %h", i, regs_flat[i*DW +: DW], model[i]);
               end
            checks++;
            if (!cmp_ok) errors++;
         end
         if (BVALID === 1'b1) chk("no_aw_w_ready_during_b", {AWREADY, WREADY}, 2'b00);
         if (RVALID === 1'b1) chk("no_arready_during_r", ARREADY, 1'b0);
      end
   end

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, output logic [1:0] resp, output int lat);
      bit to;
      int n;
      to = 1'b0;
      wr_busy = 1'b1;
      fork
         begin
            int k;
            repeat (aw_dly) @(negedge ACLK);
            AWADDR = addr; AWPROT = 3'($urandom); AWVALID = 1'b1;
            k = 0;
            while (AWREADY !== 1'b1 && k < 100) begin @(negedge ACLK); k++; end
            if (k >= 100) to = 1'b1;
            @(negedge ACLK);
            AWVALID = 1'b0;
         end
         begin
            int k;
            repeat (w_dly) @(negedge ACLK);
            WDATA = data; WSTRB = strb; WVALID = 1'b1;
            k = 0;
            while (WREADY !== 1'b1 && k < 100) begin @(negedge ACLK); k++; end
            if (k >= 100) to = 1'b1;
            @(negedge ACLK);
            WVALID = 1'b0;
         end
      join
      chk("aw_w_handshake_timeout", to, 1'b0);
      lat = 1; n = 0;
      while (BVALID !== 1'b1 && n < 100) begin @(negedge ACLK); lat++; n++; end
      chk("bvalid_timeout", n >= 100, 1'b0);
      resp = BRESP;
      repeat (b_dly) begin
         chk("bvalid_held", BVALID, 1'b1);
         chk("bresp_stable", BRESP, resp);
         chk("ready_low_in_resp", {AWREADY, WREADY}, 2'b00);
         @(negedge ACLK);
      end
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
      chk("bvalid_clear", BVALID, 1'b0);
      chk("bresp", resp, oor_of(addr) ? 2'b10 : 2'b00);
      if (!oor_of(addr))
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx_of(addr)][b*8 +: 8] = data[b*8 +: 8];
      wr_busy = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input int r_dly,
                          output logic [DW-1:0] data, output logic [1:0] resp);
      logic [DW-1:0] exp_d;
      int n;
      ARADDR = addr; ARPROT = 3'($urandom); ARVALID = 1'b1;
      n = 0;
      while (ARREADY !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
      chk("arready_timeout", n >= 100, 1'b0);
      exp_d = oor_of(addr) ? '0 : model[idx_of(addr)];
      @(negedge ACLK);
      ARVALID = 1'b0;
      n = 0;
      while (RVALID !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
      chk("rvalid_timeout", n >= 100, 1'b0);
      data = RDATA; resp = RRESP;
      chk("rdata", data, exp_d);
      chk("rresp", resp, oor_of(addr) ? 2'b10 : 2'b00);
      repeat (r_dly) begin
         @(negedge ACLK);
         chk("rvalid_held", RVALID, 1'b1);
         chk("rdata_stable", RDATA, data);
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
      chk("rvalid_clear", RVALID, 1'b0);
   endtask

   initial begin
      logic [1:0]    r;
      logic [DW-1:0] d;
      int            lat;
      logic [AW-1:0] a;

      for (int i = 0; i < NR; i++) model[i] = '0;
      repeat (3) @(negedge ACLK);
      chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
      chk("rst_valid", {BVALID, RVALID}, 2'b00);
      chk("rst_resp", {BRESP, RRESP}, 4'b0000);
      chk("rst_rdata", RDATA, 0);
      chk("rst_regs", |regs_flat, 1'b0);
      ARESETN = 1'b1;
      @(negedge ACLK);
      chk("ready_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);

      // same-cycle AW+W, latency and readback
      do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, lat);
      chk("b_latency", lat, 2);
      chk("t1_bresp", r, 2'b00);
      do_read(32'h04, 0, d, r);
      chk("t1_rdata", d, 32'hDEADBEEF);

      // W three cycles ahead of AW, slow RREADY
      do_write(32'h08, 32'h12345678, 4'hF, 3, 0, 0, r, lat);
      do_read(32'h08, 4, d, r);
      chk("t2_rdata", d, 32'h12345678);

      // strobes
      do_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r, lat);
      do_write(32'h0C, 32'h00000000, 4'b0101, 1, 0, 0, r, lat);
      do_read(32'h0C, 0, d, r);
      chk("t3_strb_rdata", d, 32'hFF00FF00);
      do_write(32'h0C, 32'h11111111, 4'b0000, 0, 2, 0, r, lat);
      chk("t3_zero_strb_bresp", r, 2'b00);
      do_read(32'h0C, 0, d, r);
      chk("t3_zero_strb_rdata", d, 32'hFF00FF00);

      // BREADY held low, back-to-back writes
      do_write(32'h10, 32'hA0A0A0A0, 4'hF, 0, 0, 5, r, lat);
      do_write(32'h10, 32'h0000BEEF, 4'b0011, 0, 0, 0, r, lat);
      do_read(32'h10, 1, d, r);
      chk("t4_rdata", d, 32'hA0A0BEEF);

      // out-of-range / aliasing
      do_write(32'h100, 32'hA5A5A5A5, 4'hF, 0, 0, 0, r, lat);
`ifdef AXI4_LITE_SUB_ADDR_CHECK_EN
      chk("t5_bresp", r, 2'b10);
      do_read(32'h100, 0, d, r);
      chk("t5_rdata", d, 32'h0);
      chk("t5_rresp", r, 2'b10);
      do_read(32'h00, 0, d, r);
      chk("t5_reg0", d, 32'h0);
`else
      chk("t5_bresp", r, 2'b00);
      do_read(32'h100, 0, d, r);
      chk("t5_rdata", d, 32'hA5A5A5A5);
      chk("t5_rresp", r, 2'b00);
      do_read(32'h00, 0, d, r);
      chk("t5_reg0", d, 32'hA5A5A5A5);
`endif

      // AR handshake in the commit cycle returns the old value
      do_write(32'h14, 32'h0BADF00D, 4'hF, 0, 0, 0, r, lat);
      fork
         do_write(32'h14, 32'hCAFEF00D, 4'hF, 0, 0, 0, r, lat);
         begin
            logic [DW-1:0] cd;
            logic [1:0]    cr;
            @(negedge ACLK);
            do_read(32'h14, 0, cd, cr);
            chk("collision_old", cd, 32'h0BADF00D);
         end
      join
      do_read(32'h14, 0, d, r);
      chk("collision_new", d, 32'hCAFEF00D);

      // randomized traffic
      for (int t = 0; t < 300; t++) begin
         a = $urandom;
         if ($urandom_range(7) != 0) a[AW-1:6] = '0;
         if ($urandom_range(1) == 0)
            do_write(a, $urandom, 4'($urandom), $urandom_range(3), $urandom_range(3),
                     $urandom_range(3), r, lat);
         else
            do_read(a, $urandom_range(3), d, r);
      end

      // reset with both responses pending
      AWADDR = 32'h18; WDATA = 32'h77777777; WSTRB = 4'hF; ARADDR = 32'h04;
      AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; wr_busy = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      repeat (3) @(negedge ACLK);
      chk("pre_rst_valids", {BVALID, RVALID}, 2'b11);
      #2 ARESETN = 1'b0;
      #1;
      chk("async_rst_valids", {BVALID, RVALID}, 2'b00);
      chk("async_rst_regs", |regs_flat, 1'b0);
      for (int i = 0; i < NR; i++) model[i] = '0;
      @(negedge ACLK);
      ARESETN = 1'b1;
      wr_busy = 1'b0;
      @(negedge ACLK);
      chk("ready_after_mid_rst", {AWREADY, WREADY, ARREADY}, 3'b111);
      do_read(32'h04, 0, d, r);
      chk("post_rst_rdata", d, 32'h0);

      for (int t = 0; t < 50; t++) begin
         a = {26'd0, 6'($urandom)};
         if ($urandom_range(1) == 0)
            do_write(a, $urandom, 4'($urandom), $urandom_range(2), $urandom_range(2),
                     $urandom_range(2), r, lat);
         else
            do_read(a, $urandom_range(2), d, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
